// File: rtl/k_ones_pattern_gen.sv
// k_ones_pattern_gen: streams every width-bit word with exactly k ones set, in
// ascending order, one word per valid/ready beat, using Gosper's successor.
module k_ones_pattern_gen #(
  parameter int unsigned width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(width):0] k,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_pattern,
  output logic                   out_last,
  output logic [width-1:0]       out_index,
  output logic                   err
);

  localparam int unsigned KW = $clog2(width) + 1;
  localparam int unsigned CW = $clog2(width + 2);
  localparam int          WI = int'(width);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [KW-1:0]    k_q, k_d;
  logic [width-1:0] pattern_q, pattern_d;
  logic [width-1:0] index_q, index_d;

  logic [width-1:0] low_bit;
  logic [width:0]   ripple;
  logic [width:0]   changed;
  logic [CW-1:0]    flips;
  logic [width-1:0] fill;
  logic [width-1:0] succ;
  logic [width-1:0] first_word;

  // Gosper's successor: carry the lowest run of ones up, refill the spill at the bottom.
  always_comb begin
    low_bit = pattern_q & (~pattern_q + width'(1));
    ripple  = {1'b0, pattern_q} + {1'b0, low_bit};
    changed = ripple ^ {1'b0, pattern_q};
    flips   = '0;
    for (int i = 0; i <= WI; i++) begin
      flips = flips + CW'(changed[i]);
    end
    fill = '0;
    for (int i = 0; i < WI; i++) begin
      fill[i] = (i + 2) < int'(flips);
    end
    succ = ripple[width-1:0] | fill;
  end

  // Lowest word of weight k: the k low bits set.
  always_comb begin
    first_word = '0;
    for (int i = 0; i < WI; i++) begin
      first_word[i] = i < int'(k);
    end
  end

  // Final word once all ones sit at the top; gated so reset/idle never flags last.
  assign out_last = valid_q &
                    ((k_q == '0) || (k_q == KW'(width)) || ripple[width]);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    k_d       = k_q;
    pattern_d = pattern_q;
    index_d   = index_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (k > KW'(width)) begin
            err_d = 1'b1;
          end else begin
            state_d   = EMIT;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            k_d       = k;
            pattern_d = first_word;
            index_d   = '0;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            pattern_d = succ;
            index_d   = index_q + width'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      k_q       <= '0;
      pattern_q <= '0;
      index_q   <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      k_q       <= k_d;
      pattern_q <= pattern_d;
      index_q   <= index_d;
    end
  end

  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign out_pattern = pattern_q;
  assign out_index   = index_q;
  assign err         = err_q;

endmodule

// File: tb/tb_k_ones_pattern_gen.sv
// Testbench for k_ones_pattern_gen: compares each streamed sequence with a
// brute-force enumeration of all weight-k words.
module tb_k_ones_pattern_gen;

  localparam int W  = 8;
  localparam int KW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_pattern;
  logic          out_last;
  logic [W-1:0]  out_index;
  logic          err;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_pat[$];
  logic [W-1:0] got_idx[$];
  logic         got_last[$];
  int           hold_bad;
  int           err_seen;
  bit           timeout;
  logic         end_busy;
  logic         end_valid;
  logic [W-1:0] stall_pat;

  k_ones_pattern_gen #(.width(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k          (k),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pattern(out_pattern),
    .out_last   (out_last),
    .out_index  (out_index),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference: every W-bit value of weight kk, in ascending order.
  task automatic build_model(input int kk);
    logic [W-1:0] vv;
    exp_q.delete();
    for (int v = 0; v < (1 << W); v++) begin
      vv = W'(v);
      if ($countones(vv) == kk) exp_q.push_back(vv);
    end
  endtask

  function automatic int seq_bad();
    int bad;
    bad = hold_bad + err_seen + (timeout ? 1000 : 0);
    if (got_pat.size() != exp_q.size()) bad += 100;
    for (int i = 0; i < int'(got_pat.size()) && i < int'(exp_q.size()); i++) begin
      if (got_pat[i] !== exp_q[i]) bad++;
      if (got_idx[i] !== W'(i)) bad++;
      if (got_last[i] !== (i == int'(exp_q.size()) - 1)) bad++;
    end
    return bad;
  endfunction

  task automatic begin_seq(input int kk);
    start = 1'b1;
    k     = KW'(kk);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Consume beats until out_valid drops (or stop_after handshakes), recording them.
  task automatic drain(input int stall_beat, input int stall_len, input bit rnd,
                       input int poke_beat, input int stop_after);
    int beat = 0;
    int stalls = 0;
    int cyc = 0;
    bit poked = 0;
    logic pv, pr, pl;
    logic [W-1:0] pp, pi;
    got_pat.delete(); got_idx.delete(); got_last.delete();
    hold_bad = 0; err_seen = 0; timeout = 0; stall_pat = '0;
    while (out_valid === 1'b1) begin
      if (cyc >= 4000) begin
        timeout = 1;
        break;
      end
      if (beat == stall_beat && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
        stall_pat = out_pattern;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (beat == poke_beat && !poked) begin
        start = 1'b1;
        k     = KW'(5);
        poked = 1;
      end
      pv = out_valid; pr = out_ready; pp = out_pattern; pi = out_index; pl = out_last;
      if (out_ready) begin
        got_pat.push_back(out_pattern);
        got_idx.push_back(out_index);
        got_last.push_back(out_last);
        beat++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (err === 1'b1) err_seen++;
      if (pv && !pr && (out_valid !== 1'b1 || out_pattern !== pp ||
                        out_index !== pi || out_last !== pl)) hold_bad++;
      if (stop_after > 0 && beat >= stop_after) break;
    end
    out_ready = 1'b0;
    end_busy  = busy;
    end_valid = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; k = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL reset_valid_busy: got %b want 00", {out_valid, busy});
    else passed++;
    total++;
    if ({out_pattern, out_index} !== '0) $display("FAIL reset_pat_idx: got %h/%h want 0/0", out_pattern, out_index);
    else passed++;
    total++;
    if ({out_last, err} !== 2'b00) $display("FAIL reset_last_err: got %b want 00", {out_last, err});
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_k3_full();
    build_model(3);
    begin_seq(3);
    total++;
    if ({busy, out_valid, out_pattern, out_index} !== {1'b1, 1'b1, 8'h07, 8'h00})
      $display("FAIL k3_first: got b%b v%b %h idx %0d want b1 v1 07 idx 0", busy, out_valid, out_pattern, out_index);
    else passed++;
    drain(-1, 0, 0, -1, 0);
    total++;
    if (seq_bad() !== 0) $display("FAIL k3_stream: got %0d bad beats want 0", seq_bad());
    else passed++;
    total++;
    if (got_pat.size() !== 56) $display("FAIL k3_count: got %0d want 56", got_pat.size());
    else passed++;
    total++;
    if (got_pat.size() == 0 || got_pat[$] !== 8'hE0 || got_idx[$] !== 8'd55 || got_last[$] !== 1'b1)
      $display("FAIL k3_final: got size %0d want last 0xE0 idx 55 out_last 1", got_pat.size());
    else passed++;
    total++;
    if ({end_busy, end_valid} !== 2'b00) $display("FAIL k3_end: got busy/valid %b want 00", {end_busy, end_valid});
    else passed++;
  endtask

  task automatic test_degenerate();
    build_model(0);
    begin_seq(0);
    drain(-1, 0, 0, -1, 0);
    total++;
    if (seq_bad() !== 0 || got_pat.size() !== 1 || got_pat[0] !== 8'h00)
      $display("FAIL k0_single: got %0d beats, bad %0d want 1 beat 0x00", got_pat.size(), seq_bad());
    else passed++;
    build_model(8);
    begin_seq(8);
    total++;
    if (out_valid !== 1'b1) $display("FAIL restart_same_cycle: got valid %b want 1", out_valid);
    else passed++;
    drain(-1, 0, 0, -1, 0);
    total++;
    if (seq_bad() !== 0 || got_pat.size() !== 1 || got_pat[0] !== 8'hFF)
      $display("FAIL k8_single: got %0d beats, bad %0d want 1 beat 0xFF", got_pat.size(), seq_bad());
    else passed++;
  endtask

  task automatic test_err();
    int cnt;
    logic first_err, any_vb;
    start = 1'b1; k = KW'(9);
    @(posedge clk); #1;
    start = 1'b0;
    first_err = err;
    cnt = int'(err);
    any_vb = out_valid | busy;
    repeat (3) begin
      @(posedge clk); #1;
      cnt += int'(err);
      any_vb |= out_valid | busy;
    end
    total++;
    if (first_err !== 1'b1 || cnt !== 1) $display("FAIL err_pulse: got first %b cycles %0d want 1 and 1", first_err, cnt);
    else passed++;
    total++;
    if (any_vb !== 1'b0) $display("FAIL err_no_beats: got valid|busy %b want 0", any_vb);
    else passed++;
  endtask

  task automatic test_backpressure();
    build_model(4);
    begin_seq(4);
    drain(1, 5, 0, -1, 0);
    total++;
    if (stall_pat !== 8'h17) $display("FAIL bp_held: got %h want 17", stall_pat);
    else passed++;
    total++;
    if (seq_bad() !== 0 || got_pat.size() !== 70) $display("FAIL bp_stream: got %0d beats bad %0d want 70 beats 0 bad", got_pat.size(), seq_bad());
    else passed++;
    total++;
    if (got_pat.size() < 3 || got_pat[2] !== 8'h1B) $display("FAIL bp_resume: got size %0d want beat 0x1B after 0x17", got_pat.size());
    else passed++;
  endtask

  task automatic test_ignore_start();
    build_model(2);
    begin_seq(2);
    drain(-1, 0, 0, 5, 0);
    total++;
    if (seq_bad() !== 0 || got_pat.size() !== 28) $display("FAIL ignore_start: got %0d beats bad %0d want 28 beats 0 bad", got_pat.size(), seq_bad());
    else passed++;
  endtask

  task automatic test_async_reset();
    build_model(3);
    begin_seq(3);
    drain(-1, 0, 0, -1, 10);
    total++;
    if (out_valid !== 1'b1 || out_index !== 8'd10) $display("FAIL pre_reset: got valid %b idx %0d want 1 10", out_valid, out_index);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, busy, out_index, out_pattern} !== '0)
      $display("FAIL async_reset: got v%b b%b idx %h pat %h want all 0", out_valid, busy, out_index, out_pattern);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL no_resume: got %b want 00", {out_valid, busy});
    else passed++;
    build_model(1);
    begin_seq(1);
    drain(-1, 0, 0, -1, 0);
    total++;
    if (seq_bad() !== 0 || got_pat.size() !== 8 || got_pat[$] !== 8'h80)
      $display("FAIL k1_after_reset: got %0d beats bad %0d want 8 beats ending 0x80", got_pat.size(), seq_bad());
    else passed++;
  endtask

  task automatic test_random();
    int kk;
    repeat (6) begin
      kk = $urandom_range(0, W);
      build_model(kk);
      begin_seq(kk);
      drain(-1, 0, 1, -1, 0);
      total++;
      if (seq_bad() !== 0) $display("FAIL random_k%0d: got %0d bad (%0d beats) want 0 bad (%0d beats)", kk, seq_bad(), got_pat.size(), exp_q.size());
      else passed++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_k3_full();
    test_degenerate();
    test_err();
    test_backpressure();
    test_ignore_start();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/k_ones_pattern_gen.md
Name: k_ones_pattern_gen

Overview:
- Inverse of the team's combinational popcount block.
- Given a requested ones-count k, emits every width-bit word with exactly k bits set, one per beat.
- Words come out in strictly increasing numeric order over a valid/ready stream.
- Used to drive exhaustive stimulus into popcount/priority logic and to generate fixed-weight codewords.
- Next word is computed in one cycle using Gosper's successor with an internal popcount; no divider.

Parameters:
- width, 8, pattern width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- k  input  $clog2(width)+1  requested ones-count; sampled with start.
- busy  output  1  high from the cycle after an accepted start until the cycle after the final handshake.
- out_valid  output  1  out_pattern is valid.
- out_ready  input  1  consumer accepts the beat when high together with out_valid.
- out_pattern  output  width  current word; popcount always equals the latched k.
- out_last  output  1  current beat is the final word of the sequence; qualified by out_valid.
- out_index  output  width  zero-based beat number within the sequence.
- err  output  1  one-cycle pulse: start was received with k > width.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, out_valid=0, out_pattern=0, out_last=0, out_index=0, err=0. An in-flight sequence is discarded; no resume after reset.
- FSM has two states: IDLE and EMIT.
- IDLE with start=1 and k<=width:
  - Next cycle: state=EMIT, busy=1, out_valid=1, out_pattern=(1<<k)-1, out_index=0.
  - k is latched internally.
- IDLE with start=1 and k>width:
  - err=1 for exactly the next cycle; state stays IDLE; no beats are produced.
- start while in EMIT is ignored; k changes during EMIT have no effect.
- EMIT, handshake rule:
  - out_valid stays high and out_pattern/out_last/out_index stay stable until out_valid&&out_ready.
  - The block makes no combinational path from out_ready to out_valid.
- EMIT, handshake on a non-last beat:
  - Next cycle: out_pattern=succ(out_pattern), out_index+=1, out_valid stays 1. Back-to-back rate is one beat per cycle.
- EMIT, handshake on the last beat:
  - Next cycle: state=IDLE, out_valid=0, busy=0.
  - A new start is accepted in that same IDLE cycle.
- Successor rule, for x=out_pattern:
  - c = x & (~x+1), i.e. lowest set bit.
  - r = x + c, computed at width+1 bits.
  - n = popcount(r ^ x) - 2.
  - succ = r[width-1:0] | ((1<<n)-1).
- out_last (combinational from registered state):
  - 1 when latched k==0, or latched k==width, or r[width]==1.
  - Equivalently, x has its k ones in the top k positions.
- Degenerate cases:
  - k=0: single beat 0, out_last=1.
  - k=width: single beat all-ones, out_last=1.
- Total beats per sequence = C(width,k). out_index of the last beat = C(width,k)-1, which fits in width bits.
- err and the beat stream never overlap.

Test Plan (width=8):
- start,k=3, out_ready=1 → beats 0x07,0x0B,0x0D,0x0E,0x13,…; 56 beats; final beat 0xE0 with out_last=1 and out_index=55; busy drops on the cycle after that beat; every beat has popcount 3 and beats strictly increase.
- start,k=0 → exactly one beat 0x00, out_last=1, out_index=0. Then start,k=8 → one beat 0xFF, out_last=1.
- start,k=9 → err high exactly one cycle; out_valid and busy stay 0.
- k=4 with out_ready held low 5 cycles on beat 2 → out_pattern holds 0x17 with out_valid=1 throughout; after release the stream continues with 0x1B; total 70 beats.
- start,k=2 pulsed again mid-sequence with k=5 → ignored; all 28 k=2 beats are produced unchanged.
- rst asserted mid-sequence (k=3, after beat 10) → out_valid, busy, out_index and out_pattern are 0 immediately (asynchronously); after release, start,k=1 yields 0x01,0x02,…,0x80 with out_last on 0x80.
